// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD        = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        FULL = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // imm is in halfword units, so shift left once; result is forced word-aligned.
    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [30:0] imm_lo);
        logic [31:0] t;
        t = base + {imm_lo, 1'b0};
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO of {pc, instr}; head is always entry 0.
// Latency: a push is visible at the head on the following edge when empty.
// Backpressure: caller must not push at count 2 without a same-cycle pop; flush beats push.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_dat,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t ent0, ent1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_dat;
                    else               ent1 <= push_dat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever survives the pop.
                    if (count == 2'd1) begin
                        ent0 <= push_dat;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = ent0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads imem combinationally, queues {pc, instr} for decode.
// Latency: 1 edge from PC presentation to out_*; redirect target valid 2 edges after the pulse.
// Backpressure: out_valid/out_ready into a 2-entry queue; PC holds when full. FETCH_STATS_EN adds counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = PC_RESET_DEFAULT,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_base,
    input  logic [63:0] redirect_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halt
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [1:0] FULL_LVL = 2'(QUEUE_DEPTH);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [1:0]   count;
    fetch_entry_t head, push_dat;
    logic         push, pop, word_zero;
    logic         unused_imm;

    assign unused_imm = ^redirect_imm[63:31];

    assign word_zero = (imem_instr == HALT_WORD);
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = (state == RUN) && ((count < FULL_LVL) || pop)
                       && !redirect_valid && !word_zero;
    assign push_dat  = '{pc: pc, instr: imem_instr};

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (word_zero)                       state_nxt = HALT;
                else if (count == FULL_LVL && !pop)  state_nxt = FULL;
            end
            FULL:    if (pop) state_nxt = RUN;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
        if (redirect_valid) state_nxt = RUN;
    end

    always_comb begin
        pc_nxt = pc;
        if (redirect_valid)  pc_nxt = branch_target(redirect_base, redirect_imm[30:0]);
        else if (push)       pc_nxt = pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= PC_RESET;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    fetch_queue u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .push_dat (push_dat),
        .count    (count),
        .head     (head)
    );

    assign imem_addr = pc;
    assign out_valid = (count != 2'd0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign halt      = (state == HALT);

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (push)                    fetch_count <= fetch_count + 32'd1;
            if (out_valid && !out_ready) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, backpressure, redirect, halt, simultaneous events.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [63:0] redirect_imm;
    logic        out_valid, out_ready, halt;
    logic [31:0] out_instr, out_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count;
`endif

    logic [31:0] mem [0:31];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign imem_instr = mem[imem_addr[6:2]];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_base  (redirect_base),
        .redirect_imm   (redirect_imm),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halt           (halt)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks head valid with the given pc and the instruction the bench placed there.
    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, mem[pc[6:2]]);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0013 | (32'(i) << 12);
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0010_2023;
        rst_n = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_base = 32'h0;
        redirect_imm = 64'h0;

        // Reset state
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // Stream after release
        tick();
        rst_n = 1'b1;
        tick();
        chk("s0_instr_lit", out_instr, 32'h0010_0093);
        chk_head("s0", 32'h0);
        chk("s0_addr", imem_addr, 32'h4);
        tick();
        chk("s1_instr_lit", out_instr, 32'h0010_2023);
        chk_head("s1", 32'h4);

        // Async reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_pc", out_pc, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);

        // Backpressure: six edges with out_ready low (five with a valid head)
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("bp_head_pc", out_pc, 32'h0);
            chk("bp_head_valid", {31'd0, out_valid}, 32'd1);
        end
        chk("bp_addr", imem_addr, 32'h8);
`ifdef FETCH_STATS_EN
        chk("bp_stall_count", stall_count, 32'd5);
        chk("bp_fetch_count", fetch_count, 32'd2);
`endif
        out_ready = 1'b1;
        tick();
        chk_head("bp_d1", 32'h4);
        tick();
        chk_head("bp_d2", 32'h8);
`ifdef FETCH_STATS_EN
        chk("bp_fetch_count2", fetch_count, 32'd3);
`endif

        // Stream on to head 0x38
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk_head("str", 32'h8 + 32'(4 * k));
        end
        chk("str_addr", imem_addr, 32'h3C);

        // Backward redirect with out_ready high
        redirect_valid = 1'b1;
        redirect_base = 32'h38;
        redirect_imm = 64'hFFFF_FFFF_FFFF_FFF0;
        tick();
        redirect_valid = 1'b0;
        chk("rd_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h18);
        tick();
        chk_head("rd_first", 32'h18);

        // Halt on zero word at 0x3C
        mem[15] = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_head("pre_halt", 32'h18 + 32'(4 * k));
        end
        chk("pre_halt_flag", {31'd0, halt}, 32'd0);
        tick();
        chk("halt_flag", {31'd0, halt}, 32'd1);
        chk("halt_valid", {31'd0, out_valid}, 32'd0);
        chk("halt_addr", imem_addr, 32'h3C);
        tick();
        chk("halt_hold_flag", {31'd0, halt}, 32'd1);
        chk("halt_hold_addr", imem_addr, 32'h3C);

        // Redirect out of halt to 0x40
        redirect_valid = 1'b1;
        redirect_base = 32'h3C;
        redirect_imm = 64'h2;
        tick();
        redirect_valid = 1'b0;
        chk("unhalt_flag", {31'd0, halt}, 32'd0);
        chk("unhalt_addr", imem_addr, 32'h40);
        chk("unhalt_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk_head("unhalt_first", 32'h40);

        // Fill to two entries, then push+pop at count 2
        out_ready = 1'b0;
        tick();
        chk_head("fill", 32'h40);
        chk("fill_addr", imem_addr, 32'h48);
        out_ready = 1'b1;
        tick();
        chk_head("pp1", 32'h44);
        tick();
        chk_head("pp2", 32'h48);
        tick();
        chk_head("pp3", 32'h4C);
        chk("pp3_addr", imem_addr, 32'h54);
        out_ready = 1'b0;
        tick();
        tick();
        chk_head("full_hold", 32'h4C);
        chk("full_addr", imem_addr, 32'h54);
        out_ready = 1'b1;
        tick();
        chk_head("full_d1", 32'h50);
        tick();
        chk_head("full_d2", 32'h54);

        // Redirect coinciding with out_ready
        redirect_valid = 1'b1;
        redirect_base = 32'h0;
        redirect_imm = 64'h8;
        tick();
        redirect_valid = 1'b0;
        chk("rdy_rd_valid", {31'd0, out_valid}, 32'd0);
        chk("rdy_rd_addr", imem_addr, 32'h10);
        tick();
        chk_head("rdy_rd_first", 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
